// File: rtl/ads127l01_emu.sv
// ads127l01_emu
//   Emulates the converter side of an ADS127L01 frame-sync serial link. Parallel
//   samples arrive on an AXI4-Stream slave, are held in a one-deep buffer and
//   are shifted out MSB first, one frame per sample, on sck/fsync/dout. The
//   block follows the receiver's start/reset_n controls like the real device.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   en                block enable (low aborts to IDLE)
//   start             run request; falling edge finishes the current frame
//   reset_n           converter reset, active low (low aborts to IDLE)
//   s_axis_*          sample input; tready is registered and means "buffer empty"
//   sck, fsync, dout  serial link; dout/fsync change on the sck falling edge
//   underflow         sticky, set when a frame starts with nothing buffered
module ads127l01_emu #(
  parameter int DW         = 24,
  parameter int FRAME_BITS = 32,
  parameter int SCK_DIV    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          reset_n,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [DW-1:0] s_axis_tdata,
  output logic          sck,
  output logic          fsync,
  output logic          dout,
  output logic          underflow
);

  localparam int DCW = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;
  localparam int BCW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(SCK_DIV - 1);
  localparam logic [DCW-1:0] DIV_RISE = DCW'(SCK_DIV / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t          state_q, state_d;
  logic [DCW-1:0]  div_q, div_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            buf_vld_q, buf_vld_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic            sck_q, sck_d;
  logic            fsync_q, fsync_d;
  logic            dout_q, dout_d;
  logic            uf_q, uf_d;
  logic            tready_q, tready_d;

  logic            div_wrap, frame_end, frame_start;
  logic [DW-1:0]   load_word;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    shreg_d     = shreg_q;
    sck_d       = sck_q;
    fsync_d     = fsync_q;
    dout_d      = dout_q;
    uf_d        = uf_q;
    div_wrap    = (div_q == DIV_LAST);
    frame_end   = div_wrap && (bit_q == BIT_LAST);
    frame_start = 1'b0;
    load_word   = buf_vld_q ? buf_q : '0;

    if (!en || !reset_n) begin
      // abort wins over everything: quiet link, flushed buffer, flag cleared
      state_d   = IDLE;
      div_d     = '0;
      bit_d     = '0;
      sck_d     = 1'b0;
      fsync_d   = 1'b0;
      dout_d    = 1'b0;
      buf_vld_d = 1'b0;
      uf_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RUN;
            frame_start = 1'b1;
          end
        end
        default: begin
          if (state_q == RUN && !start)     state_d = STOPPING;
          if (state_q == STOPPING && start) state_d = RUN;
          div_d = div_wrap ? '0 : div_q + 1'b1;
          if (div_q == DIV_RISE) sck_d = 1'b1;
          if (div_wrap) begin
            sck_d = 1'b0;
            bit_d = frame_end ? '0 : bit_q + 1'b1;
            if (!frame_end) begin
              // zeros shift in from the bottom, so bits past DW read as 0
              fsync_d = 1'b0;
              dout_d  = shreg_q[DW-2];
              shreg_d = shreg_q << 1;
            end else if (state_q == STOPPING && !start) begin
              state_d = IDLE;
              fsync_d = 1'b0;
              dout_d  = 1'b0;
            end else begin
              frame_start = 1'b1;
            end
          end
        end
      endcase

      if (frame_start) begin
        fsync_d   = 1'b1;
        shreg_d   = load_word;
        dout_d    = load_word[DW-1];
        buf_vld_d = 1'b0;
        if (!buf_vld_q) uf_d = 1'b1;
      end

      // tready is only high with the buffer empty, so this never races the
      // drain above; a fill on a frame-start edge is kept for the next frame
      if (s_axis_tvalid && tready_q) begin
        buf_d     = s_axis_tdata;
        buf_vld_d = 1'b1;
      end
    end

    tready_d = !buf_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      shreg_q   <= '0;
      sck_q     <= 1'b0;
      fsync_q   <= 1'b0;
      dout_q    <= 1'b0;
      uf_q      <= 1'b0;
      tready_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      shreg_q   <= shreg_d;
      sck_q     <= sck_d;
      fsync_q   <= fsync_d;
      dout_q    <= dout_d;
      uf_q      <= uf_d;
      tready_q  <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign sck           = sck_q;
  assign fsync         = fsync_q;
  assign dout          = dout_q;
  assign underflow     = uf_q;

endmodule

// File: tb/tb_ads127l01_emu.sv
// tb_ads127l01_emu
//   Bench for ads127l01_emu. A receiver process deserialises frames on sck
//   rising edges; a model process predicts which sample each frame carries from
//   the handshakes it sees and the buffer/underflow rules. Scenario tasks
//   compare received frames, flags and waveforms against constants and the model.
module tb_ads127l01_emu;
  localparam int DW = 24, FB = 32, SD = 4, FP = FB * SD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          start = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tready, sck, fsync, dout, underflow;

  ads127l01_emu #(.DW(DW), .FRAME_BITS(FB), .SCK_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .sck(sck), .fsync(fsync), .dout(dout), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  typedef struct { logic [DW-1:0] w; bit tail_ok; } frame_t;
  frame_t        rx_q[$];
  logic [DW-1:0] fx_q[$];
  int            fs_cyc[$];

  // ---------------- reference model: buffer occupancy and frame contents
  logic [DW-1:0] exp_q[$];
  bit            m_uf = 1'b0;
  int            cyc = 0;
  bit            m_hs, m_ab, m_fprev;
  logic [DW-1:0] m_hd;

  always @(posedge clk) begin
    m_hs    = s_axis_tvalid && s_axis_tready;
    m_hd    = s_axis_tdata;
    m_ab    = !en || !reset_n || !rst_n;
    m_fprev = fsync;
    #1;
    cyc++;
    if (m_ab) begin
      exp_q.delete();
      m_uf = 1'b0;
    end else begin
      if (fsync && !m_fprev) begin
        if (exp_q.size() > 0) fx_q.push_back(exp_q.pop_front());
        else begin
          fx_q.push_back('0);
          m_uf = 1'b1;
        end
        fs_cyc.push_back(cyc);
      end
      if (m_hs) exp_q.push_back(m_hd);
    end
  end

  // ---------------- receiver: samples dout on sck rise, fsync marks bit 0
  int            r_bit = -1;
  logic [FB-1:0] r_sr;

  always @(posedge sck) begin
    if (fsync) begin
      r_bit = 0;
      r_sr  = '0;
    end
    if (r_bit >= 0) begin
      r_sr = {r_sr[FB-2:0], dout};
      r_bit++;
      if (r_bit == FB) begin
        rx_q.push_back('{r_sr[FB-1:FB-DW], r_sr[FB-DW-1:0] == '0});
        r_bit = -1;
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons inside)
  task automatic send(input logic [DW-1:0] w, output bit ok);
    ok = 1'b0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2 * FP; k++) begin
      if (s_axis_tready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int n, output bit ok);
    for (int k = 0; k < 4 * FP && rx_q.size() < n; k++) @(negedge clk);
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_fs(input int n, output bit ok);
    for (int k = 0; k < 4 * FP && fs_cyc.size() < n; k++) @(negedge clk);
    ok = (fs_cyc.size() >= n);
  endtask

  // lands on the negedge where bit b of the current frame has just begun
  task automatic wait_bit(input int b, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FP; k++) begin
      if (fs_cyc.size() > 0 && cyc - fs_cyc[fs_cyc.size()-1] == b * SD) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0; start = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge clk);
    en = 1'b1; reset_n = 1'b1;
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    #12;
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b exp=0", sck); end
    checks++; if (fsync !== 1'b0) begin errors++; $display("FAIL reset_fsync got=%b exp=0", fsync); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b exp=0", dout); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%b exp=1", s_axis_tready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    bit ok; int r0, fc0, nfs; logic [7:0] sckv;
    restart();
    send(24'hA5C3F0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ff_send got=timeout exp=handshake"); end
    r0 = rx_q.size(); fc0 = fs_cyc.size();
    start = 1'b1;
    @(negedge clk);
    checks++; if ({fsync, sck, dout} !== 3'b101) begin errors++; $display("FAIL ff_first_edge got fsync/sck/dout=%b exp=101", {fsync, sck, dout}); end
    nfs = 0; sckv = '0;
    for (int k = 0; k < 12; k++) begin
      if (k < 8) sckv[k] = sck;
      if (fsync) nfs++;
      @(negedge clk);
    end
    checks++; if (sckv !== 8'b11001100) begin errors++; $display("FAIL ff_sck_wave got=%b exp=11001100", sckv); end
    checks++; if (nfs != SD) begin errors++; $display("FAIL ff_fsync_width got=%0d exp=%0d", nfs, SD); end
    wait_rx(r0 + 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ff_rx got=timeout exp=frame"); end
    else if (rx_q[r0].w !== 24'hA5C3F0 || !rx_q[r0].tail_ok) begin
      errors++; $display("FAIL ff_word got=%h tail_ok=%0d exp=a5c3f0 tail_ok=1", rx_q[r0].w, rx_q[r0].tail_ok);
    end
    wait_fs(fc0 + 2, ok);
    checks++;
    if (!ok || fs_cyc[fc0+1] - fs_cyc[fc0] != FP) begin
      errors++; $display("FAIL ff_period got=%0d exp=%0d", ok ? fs_cyc[fc0+1] - fs_cyc[fc0] : -1, FP);
    end
  endtask

  task automatic test_stream();
    bit ok, allok; int r0, fc0;
    logic [DW-1:0] words[4];
    words[0] = 24'h000001; words[1] = 24'h7FFFFF; words[2] = 24'h800000; words[3] = 24'h123456;
    restart();
    r0 = rx_q.size(); fc0 = fs_cyc.size();
    allok = 1'b1;
    send(words[0], ok); allok &= ok;
    start = 1'b1;
    for (int i = 1; i < 4; i++) begin send(words[i], ok); allok &= ok; end
    checks++; if (!allok) begin errors++; $display("FAIL st_send got=timeout exp=handshake"); end
    wait_rx(r0 + 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL st_rx got=timeout exp=3 frames"); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_q[r0+i].w !== words[i] || !rx_q[r0+i].tail_ok) begin
        errors++; $display("FAIL st_word%0d got=%h exp=%h", i, rx_q[r0+i].w, words[i]);
      end
    end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL st_underflow got=%b exp=0", underflow); end
    checks++;
    if (fs_cyc.size() < fc0 + 3 || fs_cyc[fc0+2] - fs_cyc[fc0] != 2 * FP) begin
      errors++; $display("FAIL st_back_to_back got=%0d exp=%0d", fs_cyc.size() >= fc0 + 3 ? fs_cyc[fc0+2] - fs_cyc[fc0] : -1, 2 * FP);
    end
  endtask

  task automatic test_underflow();
    bit ok; int r0, f0; logic [DW-1:0] w;
    restart();
    w = DW'($urandom) | 24'h800000;
    r0 = rx_q.size(); f0 = fx_q.size();
    send(w, ok);
    start = 1'b1;
    wait_rx(r0 + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL uf_rx got=timeout exp=2 frames"); end
    else begin
      checks++; if (rx_q[r0].w !== w) begin errors++; $display("FAIL uf_first got=%h exp=%h", rx_q[r0].w, w); end
      checks++; if (rx_q[r0+1].w !== '0 || !rx_q[r0+1].tail_ok) begin errors++; $display("FAIL uf_zero_frame got=%h exp=000000", rx_q[r0+1].w); end
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%b exp=1", underflow); end
    send(DW'($urandom), ok);
    wait_rx(r0 + 4, ok);
    checks++;
    if (!ok || rx_q[r0+2].w !== fx_q[f0+2] || rx_q[r0+3].w !== fx_q[f0+3]) begin
      errors++; $display("FAIL uf_later_frames got=%h,%h exp=%h,%h", ok ? rx_q[r0+2].w : 'x, ok ? rx_q[r0+3].w : 'x, fx_q[f0+2], fx_q[f0+3]);
    end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", underflow); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_stop();
    bit ok; int r0, fc0, bad; logic [DW-1:0] w;
    restart();
    w = DW'($urandom);
    r0 = rx_q.size(); fc0 = fs_cyc.size();
    send(w, ok);
    start = 1'b1;
    wait_bit(5, ok);
    start = 1'b0;
    wait_rx(r0 + 1, ok);
    checks++;
    if (!ok || rx_q[r0].w !== w || !rx_q[r0].tail_ok) begin
      errors++; $display("FAIL sp_complete got=%h exp=%h", ok ? rx_q[r0].w : 'x, w);
    end
    repeat (4) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 3 * FP / 2; k++) begin
      if (sck !== 1'b0 || fsync !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0 || fs_cyc.size() != fc0 + 1) begin errors++; $display("FAIL sp_idle got=%0d active cycles, %0d frames exp=0, 1", bad, fs_cyc.size() - fc0); end
    start = 1'b1;
    @(negedge clk);
    checks++; if (fsync !== 1'b1) begin errors++; $display("FAIL sp_restart got=%b exp=1", fsync); end
    // start dips inside a frame and returns before the frame end: no gap
    fc0 = fs_cyc.size();
    wait_bit(5, ok);
    start = 1'b0;
    repeat (5 * SD) @(negedge clk);
    start = 1'b1;
    wait_fs(fc0 + 1, ok);
    checks++;
    if (!ok || fs_cyc[fc0] - fs_cyc[fc0-1] != FP) begin
      errors++; $display("FAIL sp_no_gap got=%0d exp=%0d", ok ? fs_cyc[fc0] - fs_cyc[fc0-1] : -1, FP);
    end
  endtask

  task automatic test_abort();
    bit ok; int r0; logic [DW-1:0] x, y, z;
    restart();
    x = DW'($urandom) | 24'h000800;
    y = DW'($urandom) | 24'h400000;
    z = y ^ 24'hFFFFFF;
    send(x, ok);
    start = 1'b1;
    @(negedge clk);
    send(y, ok);
    wait_bit(12, ok);
    repeat (2) @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0 || sck !== 1'b1 || dout !== 1'b1) begin errors++; $display("FAIL ab_pre got tready/sck/dout=%b exp=011", {s_axis_tready, sck, dout}); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if ({sck, fsync, dout} !== 3'b000) begin errors++; $display("FAIL ab_outputs got=%b exp=000", {sck, fsync, dout}); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL ab_tready got=%b exp=1", s_axis_tready); end
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    r0 = rx_q.size();
    send(z, ok);
    start = 1'b1;
    wait_rx(r0 + 1, ok);
    checks++;
    if (!ok || rx_q[r0].w !== z) begin errors++; $display("FAIL ab_recover got=%h exp=%h (flushed %h)", ok ? rx_q[r0].w : 'x, z, y); end
  endtask

  task automatic test_random();
    bit ok; int r0, f0, bad, n;
    restart();
    r0 = rx_q.size(); f0 = fx_q.size();
    send(DW'($urandom), ok);
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) repeat (FP + $urandom_range(0, 40)) @(negedge clk);
      else begin
        repeat ($urandom_range(0, 60)) @(negedge clk);
        send(DW'($urandom), ok);
      end
    end
    repeat (2 * FP) @(negedge clk);
    checks++; if (underflow !== m_uf) begin errors++; $display("FAIL rnd_underflow got=%b exp=%b", underflow, m_uf); end
    n = rx_q.size() - r0;
    checks++; if (n < 20) begin errors++; $display("FAIL rnd_frames got=%0d exp>=20", n); end
    bad = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[r0+i].w !== fx_q[f0+i] || !rx_q[r0+i].tail_ok) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rnd_frame%0d got=%h exp=%h", i, rx_q[r0+i].w, fx_q[f0+i]);
      end
    end
  endtask

  task automatic test_loopback();
    bit ok, allok; int r0, bad;
    localparam int N = 300;
    restart();
    r0 = rx_q.size();
    allok = 1'b1;
    send('0, ok);
    start = 1'b1;
    for (int i = 1; i < N; i++) begin send(DW'(i), ok); allok &= ok; end
    checks++; if (!allok) begin errors++; $display("FAIL lb_send got=timeout exp=handshake"); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL lb_underflow got=%b exp=0", underflow); end
    wait_rx(r0 + N, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lb_rx got=%0d frames exp=%0d", rx_q.size() - r0, N); end
    else begin
      bad = 0;
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rx_q[r0+i].w !== DW'(i)) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL lb_sample%0d got=%h exp=%h", i, rx_q[r0+i].w, DW'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_stream();
    test_underflow();
    test_stop();
    test_abort();
    test_random();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
